// File: rtl/bmp_probe_pkg.sv
// rtl/bmp_probe_pkg.sv - shared constants, register map and FSM states for the probe
package bmp_probe_pkg;

  localparam int SCREEN_W_C = 640;
  localparam int SCREEN_H_C = 480;
  localparam int MAX_WIN_C  = 32;

  localparam logic [15:0] OFF_PX   = 16'd0;
  localparam logic [15:0] OFF_PY   = 16'd1;
  localparam logic [15:0] OFF_CMD  = 16'd2;
  localparam logic [15:0] OFF_STAT = 16'd3;
  localparam logic [15:0] OFF_ORIG = 16'd4;

  localparam int STAT_BUSY = 15;
  localparam int STAT_DONE = 14;
  localparam int STAT_CLIP = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2
  } state_t;

endpackage

// File: rtl/bmp_probe_addr.sv
// rtl/bmp_probe_addr.sv - window pixel clip check and linear video address
module bmp_probe_addr #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int WIN_W    = 5
) (
  input  logic [9:0]       i_px,
  input  logic [8:0]       i_py,
  input  logic [WIN_W-1:0] i_cx,
  input  logic [WIN_W-1:0] i_cy,
  output logic             o_clip,
  output logic [18:0]      o_raddr
);

  // One extra bit on each coordinate so origin + offset never wraps back on-screen.
  logic [10:0] w_x;
  logic [9:0]  w_y;

  assign w_x = {1'b0, i_px} + 11'(i_cx);
  assign w_y = {1'b0, i_py} + 10'(i_cy);

  assign o_clip = (w_x >= 11'(SCREEN_W)) || (w_y >= 10'(SCREEN_H));

  // y*640 + x as two shifts; the value is only used when o_clip is low.
  assign o_raddr = ({9'b0, w_y} << 9) + ({9'b0, w_y} << 7) + {8'b0, w_x};

endmodule

// File: rtl/bmp_probe.sv
// rtl/bmp_probe.sv - window readback engine counting non-key pixels in video memory
module bmp_probe
  import bmp_probe_pkg::*;
#(
  parameter int          SCREEN_W  = SCREEN_W_C,
  parameter int          SCREEN_H  = SCREEN_H_C,
  parameter logic [15:0] BASE_ADDR = 16'hC00C,
  parameter int          MAX_WIN   = MAX_WIN_C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bmp_sel,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] addr,
  input  logic [15:0] databus,
  output logic [15:0] rdata,
  output logic        vm_rd_en,
  input  logic        vm_gnt,
  output logic [18:0] vm_raddr,
  input  logic [5:0]  vm_rdata,
  output logic        busy
);

  localparam int WIN_W = $clog2(MAX_WIN);

  state_t           r_state;
  state_t           w_next;
  logic [9:0]       r_px;
  logic [8:0]       r_py;
  logic [WIN_W-1:0] r_sz;
  logic [5:0]       r_key;
  logic [WIN_W-1:0] r_cx;
  logic [WIN_W-1:0] r_cy;
  logic [10:0]      r_count;
  logic [5:0]       r_orig;
  logic             r_done;
  logic             r_clipped;
  logic             r_busy;

  logic [15:0] w_off;
  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  logic        w_start;
  logic        w_clip;
  logic [18:0] w_raddr;
  logic        w_last;
  logic        w_adv;
  logic        w_clip_hit;
  logic        w_capt;
  logic        w_unused;

  assign w_off    = addr - BASE_ADDR;
  assign w_hit    = bmp_sel && (w_off <= OFF_ORIG);
  assign w_wr     = w_hit && we;
  assign w_rd     = w_hit && re;
  assign w_start  = w_wr && !r_busy && (w_off == OFF_CMD);
  assign w_last   = (r_cx == r_sz) && (r_cy == r_sz);
  assign busy     = r_busy;
  assign w_unused = &{1'b0, databus[15:14]};

  bmp_probe_addr #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .WIN_W    (WIN_W)
  ) u_addr (
    .i_px    (r_px),
    .i_py    (r_py),
    .i_cx    (r_cx),
    .i_cy    (r_cy),
    .o_clip  (w_clip),
    .o_raddr (w_raddr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and request outputs; a clipped pixel advances without touching memory.
  always_comb begin
    w_next     = r_state;
    vm_rd_en   = 1'b0;
    vm_raddr   = '0;
    w_adv      = 1'b0;
    w_clip_hit = 1'b0;
    w_capt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_clip) begin
          w_clip_hit = 1'b1;
          w_adv      = 1'b1;
        end else begin
          vm_rd_en = 1'b1;
          vm_raddr = w_raddr;
          if (vm_gnt) w_next = ST_CAPT;
        end
      end
      ST_CAPT: begin
        w_capt = 1'b1;
        w_adv  = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_adv) w_next = w_last ? ST_IDLE : ST_ISSUE;
  end

  // Register file, scan cursor and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px      <= '0;
      r_py      <= '0;
      r_sz      <= '0;
      r_key     <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_count   <= '0;
      r_orig    <= '0;
      r_done    <= 1'b0;
      r_clipped <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_wr && !r_busy && (w_off == OFF_PX)) r_px <= databus[9:0];
      if (w_wr && !r_busy && (w_off == OFF_PY)) r_py <= databus[8:0];
      if (w_start) begin
        r_sz      <= databus[WIN_W-1:0];
        r_key     <= databus[13:8];
        r_count   <= '0;
        r_clipped <= 1'b0;
        r_cx      <= '0;
        r_cy      <= '0;
        r_busy    <= 1'b1;
      end
      if (w_clip_hit) r_clipped <= 1'b1;
      if (w_capt) begin
        if (vm_rdata != r_key) r_count <= r_count + 11'd1;
        if ((r_cx == '0) && (r_cy == '0)) r_orig <= vm_rdata;
      end
      if (w_adv) begin
        if (r_cx < r_sz) begin
          r_cx <= r_cx + 1'b1;
        end else if (r_cy < r_sz) begin
          r_cx <= '0;
          r_cy <= r_cy + 1'b1;
        end else begin
          r_busy <= 1'b0;
        end
      end
      // Completion beats a concurrent status read so done is never lost.
      if (w_adv && w_last)                            r_done <= 1'b1;
      else if (w_start || (w_rd && w_off == OFF_STAT)) r_done <= 1'b0;
    end
  end

  // Combinational readback; zero unless this block is being read.
  always_comb begin
    rdata = 16'h0;
    if (w_rd) begin
      if (w_off == OFF_STAT) rdata = {r_busy, r_done, r_clipped, 2'b00, r_count};
      if (w_off == OFF_ORIG) rdata = {10'b0, r_orig};
    end
  end

endmodule

// File: tb/tb_bmp_probe.sv
// tb/tb_bmp_probe.sv - self-checking bench for bmp_probe
module tb_bmp_probe;

  localparam logic [15:0] BASE = 16'hC00C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bmp_sel = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] databus = 16'h0;
  logic [15:0] rdata;
  logic        vm_rd_en;
  logic        vm_gnt = 1'b1;
  logic [18:0] vm_raddr;
  logic [5:0]  vm_rdata = 6'h0;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_q[$];
  logic [5:0]  ovr[int];
  logic [10:0] exp_count;
  logic        exp_clip;
  logic [5:0]  exp_orig = 6'h0;
  logic [15:0] rd;

  bmp_probe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bmp_sel  (bmp_sel),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .databus  (databus),
    .rdata    (rdata),
    .vm_rd_en (vm_rd_en),
    .vm_gnt   (vm_gnt),
    .vm_raddr (vm_raddr),
    .vm_rdata (vm_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] pix(input int a);
    if (ovr.exists(a)) return ovr[a];
    return 6'((a % 63) + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Video memory: data returned the cycle after an accepted request.
  always @(posedge clk) begin
    if (vm_rd_en && vm_gnt) vm_rdata <= pix(int'(vm_raddr));
    else                    vm_rdata <= 6'h2A;
  end

  // Scoreboard: every request (stalled or accepted) must show the next expected address.
  always @(negedge clk) begin
    if (rst_n && vm_rd_en) begin
      chk("raddr", {13'b0, vm_raddr}, (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF);
      if (vm_gnt && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] off, input logic [15:0] d);
    bmp_sel = 1'b1; we = 1'b1; addr = BASE + off; databus = d;
    tick();
    bmp_sel = 1'b0; we = 1'b0; addr = 16'h0; databus = 16'h0;
  endtask

  task automatic bus_rd(input logic [15:0] off, output logic [15:0] d);
    bmp_sel = 1'b1; re = 1'b1; addr = BASE + off;
    #1 d = rdata;
    tick();
    bmp_sel = 1'b0; re = 1'b0; addr = 16'h0;
  endtask

  task automatic model(input int px, input int py, input int sz, input logic [5:0] key);
    exp_count = '0;
    exp_clip  = 1'b0;
    for (int cy = 0; cy <= sz; cy++) begin
      for (int cx = 0; cx <= sz; cx++) begin
        int x, y, a;
        x = px + cx;
        y = py + cy;
        if (x >= 640 || y >= 480) begin
          exp_clip = 1'b1;
        end else begin
          a = y * 640 + x;
          exp_q.push_back(a);
          if (pix(a) != key) exp_count++;
          if (cx == 0 && cy == 0) exp_orig = pix(a);
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk("busy_timeout", {31'b0, busy}, 32'h0);
    chk("queue_drained", exp_q.size(), 32'h0);
  endtask

  task automatic check_result(input string tag);
    bus_rd(16'd3, rd);
    chk({tag, "_stat"}, rd, {16'h0, 1'b0, 1'b1, exp_clip, 2'b00, exp_count});
    bus_rd(16'd4, rd);
    chk({tag, "_orig"}, rd, {26'h0, exp_orig});
  endtask

  initial begin
    ovr[0]    = 6'h3F;
    ovr[1291] = 6'h00;
    ovr[1932] = 6'h00;
    ovr[3213] = 6'h00;

    // Reset state
    #12;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rden", {31'b0, vm_rd_en}, 32'h0);
    chk("rst_raddr", {13'b0, vm_raddr}, 32'h0);
    chk("rst_rdata_idle", {16'h0, rdata}, 32'h0);
    rst_n = 1'b1;
    tick();
    bus_rd(16'd3, rd);
    chk("rst_stat", rd, 32'h0);
    bus_rd(16'd4, rd);
    chk("rst_orig", rd, 32'h0);

    // 1x1 at origin, timing of busy and done
    bus_wr(16'd0, 16'd0);
    bus_wr(16'd1, 16'd0);
    model(0, 0, 0, 6'h00);
    bus_wr(16'd2, 16'h0000);
    chk("t1_busy_T1", {31'b0, busy}, 32'h1);
    tick();
    chk("t1_busy_T2", {31'b0, busy}, 32'h1);
    tick();
    chk("t1_busy_T3", {31'b0, busy}, 32'h0);
    chk("t1_queue", exp_q.size(), 32'h0);
    check_result("t1");
    chk("t1_stat_const", {16'h0, 1'b0, 1'b1, exp_clip, 2'b00, exp_count}, 32'h4001);

    // 4x4 window with three key-coloured pixels
    bus_wr(16'd0, 16'd10);
    bus_wr(16'd1, 16'd2);
    model(10, 2, 3, 6'h00);
    bus_wr(16'd2, 16'h0003);
    wait_idle(200);
    check_result("t2");

    // Window straddling the bottom-right corner
    bus_wr(16'd0, 16'd638);
    bus_wr(16'd1, 16'd478);
    model(638, 478, 3, 6'h00);
    bus_wr(16'd2, 16'h0003);
    wait_idle(200);
    check_result("t3");

    // Grant held low during the second request
    bus_wr(16'd0, 16'd10);
    bus_wr(16'd1, 16'd2);
    model(10, 2, 3, 6'h00);
    bus_wr(16'd2, 16'h0003);
    tick();
    vm_gnt = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_rden_stall", {31'b0, vm_rd_en}, 32'h1);
      tick();
    end
    vm_gnt = 1'b1;
    wait_idle(200);
    check_result("t4");

    // Writes while busy are ignored; status read clears done
    bus_wr(16'd0, 16'd10);
    bus_wr(16'd1, 16'd2);
    model(10, 2, 3, 6'h00);
    bus_wr(16'd2, 16'h0003);
    tick();
    bus_wr(16'd0, 16'd100);
    bus_wr(16'd2, 16'h3F00);
    wait_idle(200);
    check_result("t5");
    bus_rd(16'd3, rd);
    chk("t5_done_cleared", rd, {16'h0, 3'b000, 2'b00, exp_count});

    // Reset during a 32x32 scan
    bus_wr(16'd0, 16'd0);
    bus_wr(16'd1, 16'd0);
    model(0, 0, 31, 6'h00);
    bus_wr(16'd2, 16'h001F);
    repeat (10) tick();
    exp_q.delete();
    rst_n = 1'b0;
    exp_orig = 6'h0;
    bmp_sel = 1'b1; re = 1'b1; addr = BASE + 16'd3;
    #1;
    chk("t6_busy", {31'b0, busy}, 32'h0);
    chk("t6_rden", {31'b0, vm_rd_en}, 32'h0);
    chk("t6_stat", {16'h0, rdata}, 32'h0);
    bmp_sel = 1'b0; re = 1'b0; addr = 16'h0;
    tick();
    rst_n = 1'b1;
    tick();
    model(0, 0, 0, 6'h00);
    bus_wr(16'd2, 16'h0000);
    wait_idle(20);
    check_result("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bmp_probe.md
Name: bmp_probe

Overview:
Memory-mapped readback engine for the 6-bit video memory; the read-side counterpart of the BMP placement write path. The CPU programs a probe origin and a square window size over the same bmp_sel/addr/databus bus. The block scans the window through an arbitrated videoMem read port and counts pixels whose colour differs from a key (background) colour. Software uses the result for collision detection and for pixel readback.

Parameters:
SCREEN_W, 640, visible width in pixels; also the row stride.
SCREEN_H, 480, visible height in pixels.
BASE_ADDR, 16'hC00C, first register address; the block decodes BASE_ADDR..BASE_ADDR+4.
MAX_WIN, 32, maximum window edge in pixels.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
bmp_sel  in  1  bus select for this peripheral
we  in  1  bus write strobe, qualified by bmp_sel
re  in  1  bus read strobe, qualified by bmp_sel
addr  in  16  bus address
databus  in  16  write data
rdata  out  16  read data; 16'h0 when not addressed
vm_rd_en  out  1  video memory read request
vm_gnt  in  1  read grant; a request is accepted only in a cycle where vm_rd_en=1 and vm_gnt=1
vm_raddr  out  19  read address, y*SCREEN_W + x
vm_rdata  in  6  read data, valid exactly 1 cycle after acceptance
busy  out  1  scan in progress

Behaviour:
- Register map (offsets from BASE_ADDR):
  - +0 W: PX <= databus[9:0].
  - +1 W: PY <= databus[8:0].
  - +2 W: start command. SZ <= databus[4:0] (edge = SZ+1, range 1..32). KEY <= databus[13:8].
  - +3 R: {busy, done, clipped, 2'b0, count[10:0]}.
  - +4 R: {10'b0, origin_color}.
- Writes to +0, +1 and +2 are ignored while busy=1. Reads are combinational from registers.
- A read of +3 clears done on the cycle of the read strobe. A done-set event in the same cycle wins.
- Reset state: PX=PY=SZ=KEY=0, count=0, origin_color=0, done=0, clipped=0, busy=0, vm_rd_en=0, vm_raddr=0, rdata=0, FSM=IDLE.
- FSM states:
  - IDLE: on a start write, clear count, clipped and done; cx=cy=0; busy=1; go to ISSUE.
  - ISSUE: compute x=PX+cx, y=PY+cy with widened arithmetic, no wrap.
    - If x>=SCREEN_W or y>=SCREEN_H: set clipped, do not request, advance in this cycle.
    - Otherwise drive vm_rd_en=1 and vm_raddr.
    - On vm_gnt=1 go to CAPT. On vm_gnt=0 stay, holding vm_raddr stable.
  - CAPT: sample vm_rdata.
    - If it differs from KEY, count++ (11-bit, max 1024, never overflows).
    - If cx=cy=0, origin_color <= vm_rdata.
    - Then advance.
  - Advance:
    - If cx<SZ: cx++.
    - Else if cy<SZ: cx=0, cy++.
    - Else: busy=0, done=1, go to IDLE.
- Scan order is row-major. vm_rd_en=0 in every state except ISSUE-not-clipped.
- Timing with vm_gnt tied high and no clipping: start write in cycle T, first request in T+1, busy falls after cycle T+2N where N=(SZ+1)^2. A 1x1 window finishes with done visible in T+3.
- Fully off-screen origin: every pixel is clipped, count=0, origin_color is unchanged, done after (SZ+1)^2 cycles.
- Reset mid-scan: returns to the reset state immediately. The in-flight read is discarded.

Decomposition:
- Shared package holds:
  - register offsets (OFF_PX=0, OFF_PY=1, OFF_CMD=2, OFF_STAT=3, OFF_ORIG=4);
  - status bit positions (busy 15, done 14, clipped 13);
  - screen constants;
  - the FSM state enum.
- One sub-module, bmp_probe_addr: combinational clip check plus y*640+x computed as (y<<9)+(y<<7)+x.

Test Plan:
- Write PX=0, PY=0, CMD=16'h0000 (KEY=0, 1x1); memory[0]=6'h3F -> vm_raddr=0, stat=16'h4001, orig=16'h003F, busy low 3 cycles after start.
- PX=10, PY=2, CMD={KEY=6'h00, SZ=3}; 3 of 16 pixels are 0 -> count=13. First address is 1290, last address is 5*640+13=3213.
- PX=638, PY=478, SZ=3 -> only 4 requests, addresses 306558, 306559, 307198, 307199; clipped=1; status bit13 set.
- vm_gnt low for 5 cycles during the second request -> vm_raddr and vm_rd_en stable throughout; final count unchanged versus the gnt-high run.
- Start write while busy with a different PX -> ignored, result matches the first command. Read STAT twice -> done=1 then done=0.
- Assert rst_n low mid-scan of a 32x32 window -> busy=0, vm_rd_en=0, stat=16'h0000 the next cycle. A fresh 1x1 scan then completes correctly.
